// File: rtl/wb_commit_unit_pkg.sv
// Shared WBU definitions: FSM encoding, source index map and select-width helper.
package wb_commit_unit_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_CSR = 2;

  // A single source still needs a 1-bit select port.
  function automatic int wbu_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_src_sel.sv
// Combinational NSRC:1 result mux; out-of-range selects yield zero data, not valid, not legal.
module wb_src_sel
  import wb_commit_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NSRC   = 3,
  parameter int SEL_W  = wbu_sel_w(NSRC)
) (
  input  logic [NSRC*DATA_W-1:0] i_data,
  input  logic [NSRC-1:0]        i_valid,
  input  logic [SEL_W-1:0]       i_sel,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_data_valid,
  output logic                   o_sel_legal
);

  always_comb begin
    o_data       = '0;
    o_data_valid = 1'b0;
    o_sel_legal  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (i_sel == SEL_W'(k)) begin
        o_data       = i_data[k*DATA_W +: DATA_W];
        o_data_valid = i_valid[k];
        o_sel_legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit stage: accepts one retiring instruction per handshake, waits for its
// selected source, then drives a one-cycle register-file write and the retire counter.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 3,
  parameter int SEL_W  = wbu_sel_w(NSRC),
  parameter int CNT_W  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   wen_i,
  input  logic [ADDR_W-1:0]      waddr_i,
  input  logic [SEL_W-1:0]       wsel_i,
  input  logic [NSRC*DATA_W-1:0] src_data_i,
  input  logic [NSRC-1:0]        src_valid_i,
  input  logic                   flush_i,
  output logic                   rf_wen_o,
  output logic [ADDR_W-1:0]      rf_waddr_o,
  output logic [DATA_W-1:0]      rf_wdata_o,
  output logic                   retire_o,
  output logic                   illegal_o,
  output logic [CNT_W-1:0]       retire_cnt_o
);

  logic [1:0]        r_state;
  logic              r_wen;
  logic [ADDR_W-1:0] r_waddr;
  logic [SEL_W-1:0]  r_sel;

  logic              r_rf_wen;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;
  logic              r_retire;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_in_wait;
  logic              w_accept;
  logic              w_wen;
  logic [ADDR_W-1:0] w_waddr;
  logic [SEL_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_src_data;
  logic              w_src_valid;
  logic              w_sel_legal;
  logic [1:0]        w_state_nxt;
  logic              w_commit;

  assign w_in_wait = (r_state == ST_WAIT);
  assign ready_o   = !w_in_wait && !flush_i;
  assign w_accept  = valid_i && ready_o;

  // While waiting, the latched instruction drives the mux; otherwise the incoming one does.
  assign w_wen   = w_in_wait ? r_wen   : wen_i;
  assign w_waddr = w_in_wait ? r_waddr : waddr_i;
  assign w_sel   = w_in_wait ? r_sel   : wsel_i;

  wb_src_sel #(
    .DATA_W (DATA_W),
    .NSRC   (NSRC),
    .SEL_W  (SEL_W)
  ) u_src_sel (
    .i_data       (src_data_i),
    .i_valid      (src_valid_i),
    .i_sel        (w_sel),
    .o_data       (w_src_data),
    .o_data_valid (w_src_valid),
    .o_sel_legal  (w_sel_legal)
  );

  always_comb begin
    w_state_nxt = ST_IDLE;
    w_commit    = 1'b0;
    if (w_in_wait) begin
      if (flush_i) begin
        w_state_nxt = ST_IDLE;
      end else if (w_src_valid) begin
        w_state_nxt = ST_COMMIT;
        w_commit    = 1'b1;
      end else begin
        w_state_nxt = ST_WAIT;
      end
    end else if (w_accept) begin
      // An illegal select commits immediately with zero data from the mux.
      if (!w_sel_legal || w_src_valid) begin
        w_state_nxt = ST_COMMIT;
        w_commit    = 1'b1;
      end else begin
        w_state_nxt = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_sel      <= '0;
      r_rf_wen   <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
      r_retire   <= 1'b0;
      r_illegal  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_wen   <= wen_i;
        r_waddr <= waddr_i;
        r_sel   <= wsel_i;
      end
      r_rf_wen  <= w_commit && w_wen && (w_waddr != '0) && w_sel_legal;
      r_retire  <= w_commit;
      r_illegal <= w_commit && !w_sel_legal;
      if (w_commit) begin
        r_rf_waddr <= w_waddr;
        r_rf_wdata <= w_src_data;
      end
      // The pulse is registered, so the count lags retire_o by one cycle.
      if (r_retire) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign rf_wen_o     = r_rf_wen;
  assign rf_waddr_o   = r_rf_waddr;
  assign rf_wdata_o   = r_rf_wdata;
  assign retire_o     = r_retire;
  assign illegal_o    = r_illegal;
  assign retire_cnt_o = r_cnt;

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Parametrised writeback commit stage for the WBU.
- Accepts one retiring instruction per handshake from the preceding stage. Selects its result from one of NSRC source buses, waiting for slow sources such as LSU load data.
- Drives a registered, single-cycle register-file write port and an instruction-retire counter.
- Replaces the fixed two-source ALU/LSU writeback select.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.
- NSRC, 3, number of result sources (0 = ALU, 1 = LSU, 2 = CSR by convention).
- SEL_W, $clog2(NSRC) (minimum 1), width of the source select.
- CNT_W, 64, retire counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- valid_i  in  1  upstream instruction valid.
- ready_o  out  1  unit can accept an instruction this cycle.
- wen_i  in  1  instruction writes the register file.
- waddr_i  in  ADDR_W  destination register.
- wsel_i  in  SEL_W  result source index.
- src_data_i  in  NSRC*DATA_W  packed source buses; source k occupies bits [k*DATA_W +: DATA_W].
- src_valid_i  in  NSRC  per-source data valid; tie high for sources that are always valid.
- flush_i  in  1  discard any instruction waiting for data.
- rf_wen_o  out  1  register-file write enable; one-cycle pulse.
- rf_waddr_o  out  ADDR_W  write address.
- rf_wdata_o  out  DATA_W  write data.
- retire_o  out  1  pulse, one per committed instruction.
- illegal_o  out  1  pulse; the committed instruction had wsel_i >= NSRC.
- retire_cnt_o  out  CNT_W  count of committed instructions.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - All outputs 0: rf_wen_o, rf_waddr_o, rf_wdata_o, retire_o, illegal_o, retire_cnt_o.
  - Latched wen, waddr and sel cleared.
- States:
  - IDLE: no instruction held.
  - WAIT: instruction held; selected source not yet valid.
  - COMMIT: output registers hold the committing instruction for exactly this one cycle.
- ready_o = (state != WAIT) && !flush_i. This is combinational from state and flush_i only.
- Accept = valid_i && ready_o. On accept, latch wen_i, waddr_i and wsel_i.
- On accept, the next state is decided as follows:
  - wsel_i >= NSRC: go to COMMIT. Data = 0, rf_wen_o = 0, illegal_o = 1, retire_o = 1.
  - src_valid_i[wsel_i] = 1 in the same cycle: capture the selected source data and go to COMMIT. Latency is 1 cycle from accept to rf_wen_o.
  - Otherwise: go to WAIT.
- In WAIT:
  - The next state depends on flush_i and the latched source's valid bit:
    - flush_i = 1: go to IDLE. No commit and no counter change. flush wins over a simultaneous src_valid_i.
    - src_valid_i[latched sel] = 1: capture that source's data and go to COMMIT.
    - Otherwise: remain in WAIT.
  - Source data is sampled only in the capture cycle; later changes are ignored.
- In COMMIT:
  - rf_wen_o = latched wen && (waddr != 0) && legal. Writes to x0 are suppressed, but the instruction still retires.
  - rf_waddr_o and rf_wdata_o are valid; retire_o = 1.
  - A new accept in the same cycle follows the IDLE rules, so back-to-back COMMIT gives 1 instruction per cycle.
  - With no accept, go to IDLE.
- Outputs outside COMMIT:
  - rf_wen_o, retire_o and illegal_o are 0.
  - rf_waddr_o and rf_wdata_o hold their last values (don't-care).
- retire_cnt_o:
  - Increments by 1 on every cycle in which retire_o = 1, including illegal and x0 commits.
  - Wraps from all-ones to 0.
  - The updated value is visible the cycle after the retire_o pulse.
- flush_i in IDLE or COMMIT:
  - Blocks acceptance that cycle.
  - Does not cancel a COMMIT already in progress.
- valid_i while ready_o = 0: upstream must hold its fields stable. The unit ignores the request.
- Reset asserted mid-WAIT or mid-COMMIT: the instruction is dropped; no write, no retire.

Decomposition:
- Shared WBU defines/package holds:
  - state encoding IDLE/WAIT/COMMIT;
  - source index constants SRC_ALU = 0, SRC_LSU = 1, SRC_CSR = 2;
  - SEL_W derivation.
- One sub-module: wb_src_sel, a combinational NSRC:1 mux.
  - Inputs: packed data, valid and sel.
  - Outputs: data, data_valid and sel_legal.
  - Out-of-range sel gives data 0, valid 0, sel_legal 0.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with valid_i = 1. Required: ready_o = 1, and all outputs 0 including retire_cnt_o = 0, with no accept taking effect. Release rst, then drive one ALU instruction: rf_wen_o pulses and retire_cnt_o = 1 afterwards.
- Back-to-back ALU: 4 consecutive cycles of valid_i = 1, wsel = 0, waddr = 1..4, src_data[0] = 0x10, 0x20, 0x30, 0x40, src_valid all 1. Required: rf_wen_o high for 4 consecutive cycles with matching addr/data, each one cycle after its accept; retire_cnt_o = 4.
- Late LSU: accept wsel = 1, waddr = 7, with src_valid[1] = 0 for 3 cycles, then src_valid[1] = 1 and data 0xDEADBEEF. Required: ready_o = 0 during the 3 wait cycles; rf_wen_o one cycle later with addr 7 and data 0xDEADBEEF.
- Flush: enter WAIT on LSU, then drive flush_i = 1 and src_valid[1] = 1 in the same cycle. Required: no rf_wen_o, no retire_o, retire_cnt_o unchanged, state returns to IDLE, ready_o = 1 the following cycle.
- x0 and illegal:
  - waddr = 0, wen = 1, ALU: rf_wen_o = 0, retire_o = 1.
  - wsel = 3 with NSRC = 3: rf_wen_o = 0, illegal_o = 1, rf_wdata_o = 0, retire_cnt_o incremented.
- Counter wrap: CNT_W = 4; commit 17 instructions. Required: retire_cnt_o reads 15 then wraps to 0 then 1.
